// File: rtl/nios2_system_led_pkg.sv
// Shared widths and helpers for the Nios II LED driver.
package nios2_system_led_pkg;

  localparam int LED_W = 8;
  localparam int PWM_W = 4;

  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  // Bits needed for a counter spanning 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/nios2_system_led_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module nios2_system_led_tick_gen
  import nios2_system_led_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/nios2_system_led_driver.sv
// Board LED driver: PWM dimming, masked blinking and a full-brightness flash
// on every newly lit bit.
module nios2_system_led_driver
  import nios2_system_led_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int FLASH_TICKS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led_value,
  input  logic [LED_W-1:0] led_blink,
  input  logic [PWM_W-1:0] brightness,
  output logic [LED_W-1:0] led,
  output logic             flash_busy
);

  localparam int BW = cnt_width(BLINK_TICKS);
  localparam int FW = clog2(FLASH_TICKS + 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_TICKS);
  localparam logic [PWM_W-1:0] PWM_FULL   = '1;

  logic [LED_W-1:0] val_q;
  logic [LED_W-1:0] rise;
  logic [LED_W-1:0] fall;
  logic [LED_W-1:0] flash_act;
  logic [PWM_W-1:0] pwm_cnt;
  logic [BW-1:0]    blink_cnt;
  logic             blink_phase;
  logic             pwm_on;
  logic             tick;

  nios2_system_led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rise = led_value & ~val_q;
  assign fall = ~led_value & val_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      pwm_cnt <= '0;
    end else begin
      val_q   <= led_value;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  assign pwm_on = (brightness == PWM_FULL) | (pwm_cnt < brightness);

  // Blink phase 0 is the dark half; it runs regardless of led_blink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // A rise outranks both the fall-clear and the tick decrement.
  for (genvar i = 0; i < LED_W; i++) begin : g_flash
    logic [FW-1:0] flash_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flash_cnt <= '0;
      end else if (rise[i]) begin
        flash_cnt <= FLASH_LOAD;
      end else if (fall[i]) begin
        flash_cnt <= '0;
      end else if (tick && (flash_cnt != '0)) begin
        flash_cnt <= flash_cnt - FW'(1);
      end
    end

    assign flash_act[i] = (flash_cnt != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led        <= '0;
      flash_busy <= 1'b0;
    end else begin
      led        <= flash_act | (val_q & {LED_W{pwm_on}} & (~led_blink | {LED_W{blink_phase}}));
      flash_busy <= |flash_act;
    end
  end

endmodule

// File: tb/tb_nios2_system_led_driver.sv
// Scoreboard bench for nios2_system_led_driver with small divider settings.
module tb_nios2_system_led_driver;

  localparam int CLK_DIV     = 4;
  localparam int BLINK_TICKS = 3;
  localparam int FLASH_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] led_value = '0;
  logic [7:0] led_blink = '0;
  logic [3:0] brightness = '0;
  logic [7:0] led;
  logic       flash_busy;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       busy;
    bit         chk_busy;
    string      name;
  } exp_t;

  exp_t sb[$];

  nios2_system_led_driver #(
    .CLK_DIV     (CLK_DIV),
    .BLINK_TICKS (BLINK_TICKS),
    .FLASH_TICKS (FLASH_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_value  (led_value),
    .led_blink  (led_blink),
    .brightness (brightness),
    .led        (led),
    .flash_busy (flash_busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        tests_run++;
        if (led !== sb[i].led || (sb[i].chk_busy && flash_busy !== sb[i].busy)) begin
          tests_failed++;
          $display("[TB] FAIL %s cycle %0d: led=%02h flash_busy=%0b, required led=%02h flash_busy=%0b%s",
                   sb[i].name, cyc, led, flash_busy, sb[i].led, sb[i].busy,
                   sb[i].chk_busy ? "" : " (busy not checked)");
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: expectation for cycle %0d never reached, now cycle %0d",
                 sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic checkOutput(input int c, input logic [7:0] l, input logic b,
                             input bit chk, input string name);
    exp_t e;
    e.cyc = c;
    e.led = l;
    e.busy = b;
    e.chk_busy = chk;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkRange(input int c0, input int c1, input logic [7:0] l,
                            input logic b, input bit chk, input string name);
    for (int c = c0; c <= c1; c++) checkOutput(c, l, b, chk, name);
  endtask

  task automatic waitTo(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_to: at cycle %0d, required cycle %0d", cyc, c);
    end
  endtask

  // Inputs change on the falling edge where cyc==c, so the DUT samples them on edge c+1.
  task automatic applyStimulus(input int c, input logic [7:0] v, input logic [7:0] b,
                               input logic [3:0] br);
    waitTo(c);
    led_value  = v;
    led_blink  = b;
    brightness = br;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic doReset(input logic [7:0] v, input logic [7:0] b, input logic [3:0] br,
                         input string name);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    led_value  = v;
    led_blink  = b;
    brightness = br;
    checkOutput(0, 8'h00, 1'b0, 1'b1, name);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    // Steady pattern with PWM; the power-up flash has expired by cycle 9.
    doReset(8'hA5, 8'h00, 4'd15, "reset_state");
    checkOutput(1, 8'h00, 1'b0, 1'b1, "first_edge");
    checkOutput(2, 8'hA5, 1'b1, 1'b1, "steady_start");
    checkRange(3, 7, 8'hA5, 1'b0, 1'b0, "steady_b15");
    checkOutput(8, 8'hA5, 1'b1, 1'b1, "flash_tail");
    checkRange(9, 20, 8'hA5, 1'b0, 1'b1, "steady_b15_idle");
    for (int m = 21; m <= 52; m++)
      checkOutput(m, (((m - 1) % 16) < 4) ? 8'hA5 : 8'h00, 1'b0, 1'b1, "pwm_b4");
    checkRange(53, 60, 8'h00, 1'b0, 1'b1, "pwm_b0");
    applyStimulus(20, 8'hA5, 8'h00, 4'd4);
    applyStimulus(52, 8'hA5, 8'h00, 4'd0);
    drain();

    // Flash at brightness 0, then a one-cycle 0->1->0 pulse on bit 3.
    doReset(8'h00, 8'h00, 4'd0, "reset_flash");
    checkOutput(6, 8'h00, 1'b0, 1'b1, "flash_pre");
    checkRange(7, 12, 8'h01, 1'b1, 1'b1, "flash_on");
    checkRange(13, 16, 8'h00, 1'b0, 1'b1, "flash_off");
    checkOutput(21, 8'h00, 1'b0, 1'b1, "pulse_pre");
    checkOutput(22, 8'h08, 1'b1, 1'b1, "pulse_on");
    checkRange(23, 24, 8'h00, 1'b0, 1'b1, "pulse_cleared");
    applyStimulus(5, 8'h01, 8'h00, 4'd0);
    applyStimulus(20, 8'h09, 8'h00, 4'd0);
    applyStimulus(21, 8'h01, 8'h00, 4'd0);
    drain();

    // Re-rise after a partly consumed flash restarts it; a rise on a tick loads full.
    doReset(8'h00, 8'h00, 4'd0, "reset_reload");
    checkOutput(2, 8'h00, 1'b0, 1'b1, "reload_pre");
    checkRange(3, 5, 8'h10, 1'b1, 1'b1, "reload_first");
    checkOutput(6, 8'h00, 1'b0, 1'b1, "reload_gap");
    checkRange(7, 12, 8'h10, 1'b1, 1'b1, "reload_restart");
    checkRange(13, 16, 8'h00, 1'b0, 1'b1, "reload_done");
    checkRange(17, 24, 8'h20, 1'b1, 1'b1, "tick_rise_on");
    checkRange(25, 26, 8'h00, 1'b0, 1'b1, "tick_rise_off");
    applyStimulus(1, 8'h10, 8'h00, 4'd0);
    applyStimulus(4, 8'h00, 8'h00, 4'd0);
    applyStimulus(5, 8'h10, 8'h00, 4'd0);
    applyStimulus(15, 8'h30, 8'h00, 4'd0);
    drain();

    // Blink on bits 0-1, then a bit-0 rise during the dark phase.
    doReset(8'h0F, 8'h03, 4'd15, "reset_blink");
    for (int m = 10; m <= 48; m++)
      checkOutput(m, ((((m - 1) / 12) % 2) == 1) ? 8'h0F : 8'h0C, 1'b0, 1'b1, "blink");
    checkRange(50, 51, 8'h0C, 1'b0, 1'b1, "simul_pre");
    checkRange(52, 56, 8'h0D, 1'b1, 1'b1, "simul_flash");
    checkRange(57, 60, 8'h0C, 1'b0, 1'b1, "simul_dark");
    checkRange(61, 64, 8'h0F, 1'b0, 1'b1, "simul_lit");
    applyStimulus(49, 8'h0E, 8'h03, 4'd15);
    applyStimulus(50, 8'h0F, 8'h03, 4'd15);
    drain();

    // Reset asserted while every bit is flashing.
    doReset(8'h00, 8'h00, 4'd15, "reset_pre_mid");
    checkRange(4, 5, 8'hFF, 1'b1, 1'b1, "mid_active");
    applyStimulus(2, 8'hFF, 8'h00, 4'd15);
    waitTo(5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput(0, 8'h00, 1'b0, 1'b1, "mid_reset");
    @(negedge clk);
    led_value = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    checkRange(1, 20, 8'h00, 1'b0, 1'b1, "post_reset_dark");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
